// File: rtl/eq_biquad_scheduler.sv
// Two cascaded biquad shelves (bass then treble) time-shared on one
// 32x16 signed multiplier and a 52-bit accumulator. Each accepted sample
// runs 5 MAC steps plus a rounding/saturating FINAL step per stage.
//
// state  | meaning
// IDLE   | waiting for i_valid; accepts sample and latches coefficients
// MAC    | one product per cycle into acc, steps 0..4 of current stage
// FINAL  | round, saturate, update stage history, advance stage or emit
// BYPASS | emit the latched sample unfiltered and clear all history
module eq_biquad_scheduler #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int FRAC   = 28
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic                       i_enable,
  input  logic signed [DATA_W-1:0]   i_data,
  input  logic        [5*COEF_W-1:0] i_coef_s0,
  input  logic        [5*COEF_W-1:0] i_coef_s1,
  output logic signed [DATA_W-1:0]   o_data,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_overrun
);

  localparam int ACC_W  = 52;
  localparam int PROD_W = COEF_W + DATA_W;

  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_FINAL  = 2'd2,
    S_BYPASS = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic        [2:0]          step_q;
  logic                       stage_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   x_cur_q;
  logic        [5*COEF_W-1:0] coef_q [2];
  logic signed [DATA_W-1:0]   x1_q [2];
  logic signed [DATA_W-1:0]   x2_q [2];
  logic signed [DATA_W-1:0]   y1_q [2];
  logic signed [DATA_W-1:0]   y2_q [2];

  logic                       accept;
  logic        [5*COEF_W-1:0] coef_set;
  logic signed [COEF_W-1:0]   coef_sel;
  logic signed [DATA_W-1:0]   opnd_sel;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_rnd;
  logic signed [ACC_W-1:0]    acc_shr;
  logic signed [DATA_W-1:0]   result;

  // The o_valid cycle still counts as busy, so a strobe there is dropped.
  assign o_busy = (state_q != S_IDLE) || o_valid;
  assign accept = i_valid && (state_q == S_IDLE) && !o_valid;

  // Select coefficient and operand for the current MAC step.
  always_comb begin
    coef_set = coef_q[stage_q];
    coef_sel = '0;
    opnd_sel = '0;
    case (step_q)
      3'd0: begin
        coef_sel = coef_set[4*COEF_W +: COEF_W];
        opnd_sel = x_cur_q;
      end
      3'd1: begin
        coef_sel = coef_set[3*COEF_W +: COEF_W];
        opnd_sel = x1_q[stage_q];
      end
      3'd2: begin
        coef_sel = coef_set[2*COEF_W +: COEF_W];
        opnd_sel = x2_q[stage_q];
      end
      3'd3: begin
        coef_sel = coef_set[1*COEF_W +: COEF_W];
        opnd_sel = y1_q[stage_q];
      end
      default: begin
        coef_sel = coef_set[0 +: COEF_W];
        opnd_sel = y2_q[stage_q];
      end
    endcase
  end

  // Shared multiplier, then round-half-up and saturate the accumulator.
  always_comb begin
    prod     = coef_sel * opnd_sel;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_rnd  = acc_q + RND;
    acc_shr  = acc_rnd >>> FRAC;
    if (acc_shr > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (acc_shr < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end else begin
      result = acc_shr[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = i_enable ? S_MAC : S_BYPASS;
        end
      end
      S_MAC: begin
        if (step_q == 3'd4) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        state_d = stage_q ? S_IDLE : S_MAC;
      end
      S_BYPASS: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: sample/coef latch, accumulator, histories and outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_q    <= '0;
      stage_q   <= 1'b0;
      acc_q     <= '0;
      x_cur_q   <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        coef_q[s] <= '0;
        x1_q[s]   <= '0;
        x2_q[s]   <= '0;
        y1_q[s]   <= '0;
        y2_q[s]   <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      if (i_valid && o_busy) begin
        o_overrun <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_cur_q   <= i_data;
            coef_q[0] <= i_coef_s0;
            coef_q[1] <= i_coef_s1;
            stage_q   <= 1'b0;
            step_q    <= '0;
          end
        end
        S_MAC: begin
          // b1/b2 terms are subtracted here rather than negating coefficients.
          case (step_q)
            3'd0:         acc_q <= prod_ext;
            3'd1, 3'd2:   acc_q <= acc_q + prod_ext;
            default:      acc_q <= acc_q - prod_ext;
          endcase
          step_q <= (step_q == 3'd4) ? 3'd0 : step_q + 3'd1;
        end
        S_FINAL: begin
          x2_q[stage_q] <= x1_q[stage_q];
          x1_q[stage_q] <= x_cur_q;
          y2_q[stage_q] <= y1_q[stage_q];
          y1_q[stage_q] <= result;
          step_q        <= '0;
          if (!stage_q) begin
            x_cur_q <= result;
            stage_q <= 1'b1;
          end else begin
            o_data  <= result;
            o_valid <= 1'b1;
            stage_q <= 1'b0;
          end
        end
        S_BYPASS: begin
          o_data  <= x_cur_q;
          o_valid <= 1'b1;
          for (int s = 0; s < 2; s++) begin
            x1_q[s] <= '0;
            x2_q[s] <= '0;
            y1_q[s] <= '0;
            y2_q[s] <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_biquad_scheduler.sv
// Bench for eq_biquad_scheduler: directed cases followed by random samples,
// each compared against a floating-free integer biquad model of both stages.
module tb_eq_biquad_scheduler;

  localparam int DATA_W = 16;
  localparam int COEF_W = 32;
  localparam int FRAC   = 28;

  logic                       i_clk;
  logic                       i_rst;
  logic                       i_valid;
  logic                       i_enable;
  logic signed [DATA_W-1:0]   i_data;
  logic        [5*COEF_W-1:0] i_coef_s0;
  logic        [5*COEF_W-1:0] i_coef_s1;
  logic signed [DATA_W-1:0]   o_data;
  logic                       o_valid;
  logic                       o_busy;
  logic                       o_overrun;

  eq_biquad_scheduler #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_enable  (i_enable),
    .i_data    (i_data),
    .i_coef_s0 (i_coef_s0),
    .i_coef_s1 (i_coef_s1),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: per-stage direct-form history and sticky overrun flag.
  longint mx1 [2];
  longint mx2 [2];
  longint my1 [2];
  longint my2 [2];
  bit     m_ovr;

  function automatic logic [159:0] pk(input int a0, input int a1, input int a2,
                                      input int b1, input int b2);
    return {a0, a1, a2, b1, b2};
  endfunction

  function automatic longint cf(input logic [159:0] s, input int idx);
    logic signed [31:0] c;
    c = s[(4-idx)*32 +: 32];
    return longint'(c);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic longint model_stage(input int s, input logic [159:0] c,
                                         input longint x);
    longint acc, y;
    acc = cf(c,0)*x + cf(c,1)*mx1[s] + cf(c,2)*mx2[s]
        - cf(c,3)*my1[s] - cf(c,4)*my2[s];
    y = (acc + 134217728) >>> 28;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    mx2[s] = mx1[s]; mx1[s] = x;
    my2[s] = my1[s]; my1[s] = y;
    return y;
  endfunction

  function automatic longint model_sample(input longint x, input bit en,
                                          input logic [159:0] c0,
                                          input logic [159:0] c1);
    longint y0;
    if (!en) begin
      model_clear();
      return x;
    end
    y0 = model_stage(0, c0, x);
    return model_stage(1, c1, y0);
  endfunction

  // Send one sample, optionally inject a dropped strobe at busy cycle 'inject'
  // (1-based count of negedges after accept), then idle for 'gap' cycles.
  task automatic run_sample(input logic signed [15:0] d, input bit en,
                            input logic [159:0] c0, input logic [159:0] c1,
                            input int inject, input int gap);
    longint exp_y;
    int     exp_lat, lat, stray;
    bit     seen;
    exp_y   = model_sample(longint'(d), en, c0, c1);
    exp_lat = en ? 12 : 1;
    seen    = 1'b0;
    lat     = -1;
    stray   = 0;
    i_data    = d;
    i_enable  = en;
    i_coef_s0 = c0;
    i_coef_s1 = c1;
    i_valid   = 1'b1;
    @(negedge i_clk);
    i_valid   = 1'b0;
    i_coef_s0 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_coef_s1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_data    = 16'($urandom);
    i_enable  = 1'($urandom);
    chk("busy_after_accept", o_busy, 1);
    for (int j = 1; j <= 20; j++) begin
      if (j > 1) @(negedge i_clk);
      i_valid = 1'b0;
      if (j == inject) begin
        i_valid = 1'b1;
        m_ovr   = 1'b1;
      end
      if (o_valid) begin
        seen = 1'b1;
        lat  = j - 1;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    chk("data", o_data, exp_y);
    chk("busy_at_valid", o_busy, 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("valid_width", o_valid, 0);
    chk("data_hold", o_data, exp_y);
    chk("overrun", o_overrun, m_ovr);
    repeat (gap) begin
      @(negedge i_clk);
      if (o_valid) stray++;
    end
    chk("stray_valid", stray, 0);
    chk("idle_not_busy", o_busy, 0);
  endtask

  function automatic int rc();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1, 2:    return int'($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000;
      default: return 0;
    endcase
  endfunction

  logic [159:0] unity, x2, rec;
  int           stray;

  initial begin
    unity = pk(268435456, 0, 0, 0, 0);
    x2    = pk(536870912, 0, 0, 0, 0);
    rec   = pk(268435456, 0, 0, -134217728, 0);
    i_rst = 1'b1; i_valid = 1'b0; i_enable = 1'b0; i_data = '0;
    i_coef_s0 = '0; i_coef_s1 = '0;
    model_clear();
    m_ovr = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overrun", o_overrun, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    run_sample(16'sd1000, 1, unity, unity, 0, 14);
    run_sample(-16'sd1234, 1, unity, unity, 0, 14);
    run_sample(16'sd20000, 1, x2, unity, 0, 14);
    chk("sat_pos", o_data, 32767);
    run_sample(-16'sd20000, 1, x2, unity, 0, 14);
    chk("sat_neg", o_data, -32768);

    run_sample(16'sd777, 0, unity, unity, 0, 14);
    run_sample(16'sd16384, 1, rec, unity, 0, 14);
    run_sample(16'sd0, 1, rec, unity, 0, 14);
    run_sample(16'sd0, 1, rec, unity, 0, 14);
    run_sample(16'sd0, 1, rec, unity, 0, 14);
    chk("recursion_4th", o_data, 2048);

    run_sample(16'sd100, 1, unity, unity, 5, 14);
    run_sample(16'sd200, 1, unity, unity, 13, 14);
    run_sample(16'sd300, 0, unity, unity, 2, 14);
    chk("overrun_sticky", o_overrun, 1);

    run_sample(16'sd16384, 1, rec, unity, 0, 14);
    chk("reenable_clean", o_data, 16384);

    // Reset mid-flight: the in-flight sample must never emerge.
    i_data = 16'sd4321; i_enable = 1'b1; i_coef_s0 = unity; i_coef_s1 = unity;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("midrst_data", o_data, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_overrun", o_overrun, 0);
    model_clear();
    m_ovr = 1'b0;
    stray = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (16) begin
      @(negedge i_clk);
      if (o_valid) stray++;
    end
    chk("midrst_no_valid", stray, 0);
    run_sample(16'sd500, 1, unity, unity, 0, 14);

    for (int n = 0; n < 60; n++) begin
      logic [159:0] c0, c1;
      bit           en;
      int           inj;
      c0  = pk(rc(), rc(), rc(), rc(), rc());
      c1  = pk(rc(), rc(), rc(), rc(), rc());
      en  = ($urandom_range(0, 3) != 0);
      inj = 0;
      if ($urandom_range(0, 4) == 0) inj = $urandom_range(1, en ? 13 : 2);
      run_sample(16'($urandom), en, c0, c1, inj, 14);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
